// File: rtl/assemble_packet_pkg.sv
// assemble_packet_pkg
// Shared constants for the printer frame packer: frame geometry, byte
// positions of the coordinate fields and checksum, default parameters,
// and a helper that builds the column mask for a given board width.
// Build option: ASSEMBLE_PACKET_CHECKSUM_EN (used by assemble_packet).
package assemble_packet_pkg;

    localparam int PACKET_W   = 176;
    localparam int NUM_BYTES  = 22;
    localparam int BITFIELD_W = 40;

    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

    // Byte positions inside the frame (byte 0 is the most significant byte).
    localparam int IDX_PX   = 1;
    localparam int IDX_PY   = 2;
    localparam int IDX_W1Y  = 3;
    localparam int IDX_W2Y  = 9;
    localparam int IDX_W3Y  = 15;
    localparam int IDX_CSUM = 21;

    localparam int DEF_BOARD_WIDTH  = 40;
    localparam int DEF_BOARD_HEIGHT = 20;

    // Ones in every column that exists on the board, zeros beyond it.
    function automatic logic [BITFIELD_W-1:0] width_mask(input int width);
        logic [BITFIELD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BITFIELD_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/assemble_packet_coord_clamp.sv
// coord_clamp
// Purely combinational clamp of one 8-bit board coordinate to 0..D-1.
// Values with bit 7 set are treated as a negative underflow and give 0;
// values from D to 127 saturate to D-1.
// Ports:
//   coord_in  : raw coordinate
//   coord_out : clamped coordinate
module coord_clamp #(
    parameter int D = 40
) (
    input  logic [7:0] coord_in,
    output logic [7:0] coord_out
);

    always_comb begin
        coord_out = coord_in;
        if (coord_in[7]) begin
            coord_out = 8'h00;
        end else if (coord_in >= 8'(D)) begin
            coord_out = 8'(D - 1);
        end
    end

endmodule

// File: rtl/assemble_packet.sv
// assemble_packet
// Packs the game state into a 22-byte frame for the serial screen printer
// and registers it every cycle (no enable, no handshake: inputs sampled at
// one edge appear on packet right after that edge).
// Build option: define ASSEMBLE_PACKET_CHECKSUM_EN to place the XOR of
// bytes 1..20 in byte 21; otherwise byte 21 is always 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   player_x/player_y : player position (clamped to the board)
//   waveN_y           : row of wave N (clamped to the board height)
//   waveN_bitfield    : per-column occupancy of wave N (masked to the width)
//   packet            : registered frame, byte k at packet[175-8k -: 8]
//   packet_update     : one-cycle pulse when the loaded frame changed
module assemble_packet
    import assemble_packet_pkg::*;
#(
    parameter int         BOARD_WIDTH  = DEF_BOARD_WIDTH,
    parameter int         BOARD_HEIGHT = DEF_BOARD_HEIGHT,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            player_x,
    input  logic [7:0]            player_y,
    input  logic [7:0]            wave1_y,
    input  logic [7:0]            wave2_y,
    input  logic [7:0]            wave3_y,
    input  logic [BITFIELD_W-1:0] wave1_bitfield,
    input  logic [BITFIELD_W-1:0] wave2_bitfield,
    input  logic [BITFIELD_W-1:0] wave3_bitfield,
    output logic [PACKET_W-1:0]   packet,
    output logic                  packet_update
);

    localparam logic [BITFIELD_W-1:0] COL_MASK = width_mask(BOARD_WIDTH);

    logic [7:0] px_c, py_c, w1y_c, w2y_c, w3y_c;
    logic [BITFIELD_W-1:0] w1_m, w2_m, w3_m;
    logic [7:0] frame_bytes [NUM_BYTES];
    logic [PACKET_W-1:0] next_packet;

    coord_clamp #(.D(BOARD_WIDTH))  u_clamp_px  (.coord_in(player_x), .coord_out(px_c));
    coord_clamp #(.D(BOARD_HEIGHT)) u_clamp_py  (.coord_in(player_y), .coord_out(py_c));
    coord_clamp #(.D(BOARD_HEIGHT)) u_clamp_w1y (.coord_in(wave1_y),  .coord_out(w1y_c));
    coord_clamp #(.D(BOARD_HEIGHT)) u_clamp_w2y (.coord_in(wave2_y),  .coord_out(w2y_c));
    coord_clamp #(.D(BOARD_HEIGHT)) u_clamp_w3y (.coord_in(wave3_y),  .coord_out(w3y_c));

    assign w1_m = wave1_bitfield & COL_MASK;
    assign w2_m = wave2_bitfield & COL_MASK;
    assign w3_m = wave3_bitfield & COL_MASK;

    always_comb begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            frame_bytes[k] = 8'h00;
        end
        frame_bytes[0]       = HEADER;
        frame_bytes[IDX_PX]  = px_c;
        frame_bytes[IDX_PY]  = py_c;
        frame_bytes[IDX_W1Y] = w1y_c;
        frame_bytes[IDX_W2Y] = w2y_c;
        frame_bytes[IDX_W3Y] = w3y_c;
        // Each bitfield follows its row byte, most significant byte first.
        for (int j = 0; j < 5; j++) begin
            frame_bytes[IDX_W1Y + 1 + j] = w1_m[BITFIELD_W-1-8*j -: 8];
            frame_bytes[IDX_W2Y + 1 + j] = w2_m[BITFIELD_W-1-8*j -: 8];
            frame_bytes[IDX_W3Y + 1 + j] = w3_m[BITFIELD_W-1-8*j -: 8];
        end
`ifdef ASSEMBLE_PACKET_CHECKSUM_EN
        // Header is excluded; the checksum covers the payload only.
        for (int k = 1; k < IDX_CSUM; k++) begin
            frame_bytes[IDX_CSUM] = frame_bytes[IDX_CSUM] ^ frame_bytes[k];
        end
`else
        frame_bytes[IDX_CSUM] = 8'h00;
`endif
    end

    always_comb begin
        next_packet = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            next_packet[PACKET_W-1-8*k -: 8] = frame_bytes[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            packet        <= {HEADER, {(PACKET_W-8){1'b0}}};
            packet_update <= 1'b0;
        end else begin
            packet        <= next_packet;
            // Compared against the frame held before this edge, so a change
            // that disappears under clamping or masking gives no pulse.
            packet_update <= (next_packet != packet);
        end
    end

endmodule

// File: tb/tb_assemble_packet.sv
module tb_assemble_packet;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  player_x, player_y, wave1_y, wave2_y, wave3_y;
    logic [39:0] wave1_bitfield, wave2_bitfield, wave3_bitfield;
    logic [175:0] packet_a, packet_b;
    logic         update_a, update_b;

    // Default build: 40 x 20 board, header AA.
    assemble_packet dut_a (
        .clk(clk), .rst(rst),
        .player_x(player_x), .player_y(player_y),
        .wave1_y(wave1_y), .wave2_y(wave2_y), .wave3_y(wave3_y),
        .wave1_bitfield(wave1_bitfield), .wave2_bitfield(wave2_bitfield),
        .wave3_bitfield(wave3_bitfield),
        .packet(packet_a), .packet_update(update_a)
    );

    // Narrow board: 32 columns, 100 rows, different header.
    assemble_packet #(.BOARD_WIDTH(32), .BOARD_HEIGHT(100), .HEADER(8'h5C)) dut_b (
        .clk(clk), .rst(rst),
        .player_x(player_x), .player_y(player_y),
        .wave1_y(wave1_y), .wave2_y(wave2_y), .wave3_y(wave3_y),
        .wave1_bitfield(wave1_bitfield), .wave2_bitfield(wave2_bitfield),
        .wave3_bitfield(wave3_bitfield),
        .packet(packet_b), .packet_update(update_b)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    function automatic int clamp_ref(input int v, input int d);
        if (v >= 128) return 0;
        if (v >= d) return d - 1;
        return v;
    endfunction

    function automatic logic [175:0] frame_ref(input int w, input int h, input logic [7:0] hdr);
        logic [7:0] b [22];
        logic [39:0] bf [3];
        int ys [3];
        logic [175:0] f;
        bf[0] = wave1_bitfield; bf[1] = wave2_bitfield; bf[2] = wave3_bitfield;
        ys[0] = wave1_y; ys[1] = wave2_y; ys[2] = wave3_y;
        for (int k = 0; k < 22; k++) b[k] = 8'h00;
        b[0] = hdr;
        b[1] = 8'(clamp_ref(player_x, w));
        b[2] = 8'(clamp_ref(player_y, h));
        for (int n = 0; n < 3; n++) begin
            logic [39:0] m;
            m = '0;
            for (int i = 0; i < 40; i++) m[i] = (i < w) ? bf[n][i] : 1'b0;
            b[3 + 6*n] = 8'(clamp_ref(ys[n], h));
            for (int j = 0; j < 5; j++) b[4 + 6*n + j] = m[39-8*j -: 8];
        end
`ifdef ASSEMBLE_PACKET_CHECKSUM_EN
        for (int k = 1; k <= 20; k++) b[21] = b[21] ^ b[k];
`endif
        f = '0;
        for (int k = 0; k < 22; k++) f[175-8*k -: 8] = b[k];
        return f;
    endfunction

    function automatic logic [7:0] byte_of(input logic [175:0] f, input int k);
        return f[175-8*k -: 8];
    endfunction

    logic [175:0] exp_a, exp_b;
    logic         exp_upd_a, exp_upd_b;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [175:0] got, input logic [175:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Predict what the coming edge loads, clock it, then check #1 after.
    task automatic step(input string tag);
        logic [175:0] na, nb;
        na = rst ? {8'hAA, 168'h0} : frame_ref(40, 20, 8'hAA);
        nb = rst ? {8'h5C, 168'h0} : frame_ref(32, 100, 8'h5C);
        exp_upd_a = !rst && (na != exp_a);
        exp_upd_b = !rst && (nb != exp_b);
        exp_a = na;
        exp_b = nb;
        @(posedge clk);
        #1;
        check({tag, "_pkt_a"}, packet_a, exp_a);
        check({tag, "_upd_a"}, {175'h0, update_a}, {175'h0, exp_upd_a});
        check({tag, "_pkt_b"}, packet_b, exp_b);
        check({tag, "_upd_b"}, {175'h0, update_b}, {175'h0, exp_upd_b});
    endtask

    task automatic set_all(input logic [7:0] x, input logic [7:0] y, input logic [7:0] wy,
                           input logic [39:0] bf);
        player_x = x; player_y = y;
        wave1_y = wy; wave2_y = wy; wave3_y = wy;
        wave1_bitfield = bf; wave2_bitfield = bf; wave3_bitfield = bf;
    endtask

    task automatic randomize_inputs();
        logic [63:0] r;
        player_x = 8'($urandom_range(0, 255));
        player_y = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
        wave1_y  = 8'($urandom_range(0, 255));
        wave2_y  = 8'($urandom_range(0, 25));
        wave3_y  = 8'($urandom_range(90, 140));
        r = {$urandom(), $urandom()}; wave1_bitfield = r[39:0];
        r = {$urandom(), $urandom()}; wave2_bitfield = r[39:0];
        r = {$urandom(), $urandom()}; wave3_bitfield = r[39:0];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_csum;
        exp_a = '0;
        exp_b = '0;
        set_all(8'd0, 8'd0, 8'd0, 40'h0);

        // Reset held for two cycles.
        rst = 1'b1;
        step("reset0");
        step("reset1");
        check("reset_const", packet_a, {8'hAA, 168'h0});

        // Nominal frame.
        rst = 1'b0;
        set_all(8'd10, 8'd1, 8'd18, 40'hFF_FFFF_FFFF);
        step("nominal");
        check("nominal_upd_const", {175'h0, update_a}, {175'h0, 1'b1});
        check("nominal_b1_3", {152'h0, byte_of(packet_a, 1), byte_of(packet_a, 2), byte_of(packet_a, 3)},
              {152'h0, 24'h0A0112});
        check("nominal_b4_8", {136'h0, packet_a[143:104]}, {136'h0, 40'hFF_FFFF_FFFF});
`ifdef ASSEMBLE_PACKET_CHECKSUM_EN
        exp_csum = 8'hE6;
`else
        exp_csum = 8'h00;
`endif
        check("nominal_csum", {168'h0, byte_of(packet_a, 21)}, {168'h0, exp_csum});
        // Narrow board masks columns 32..39.
        check("mask_b4_8", {136'h0, packet_b[143:104]}, {136'h0, 40'h00_FFFF_FFFF});
        step("hold1");
        step("hold2");

        // Clamping.
        player_x = 8'd45;
        step("x45");
        check("x45_byte", {168'h0, byte_of(packet_a, 1)}, {168'h0, 8'h27});
        player_x = 8'd50;
        step("x50_nopulse");
        check("x50_upd_const", {175'h0, update_a}, {175'h0, 1'b0});
        player_x = 8'd255;
        step("x255");
        check("x255_byte", {168'h0, byte_of(packet_a, 1)}, {168'h0, 8'h00});
        player_y = 8'd20;
        step("y20");
        check("y20_byte", {168'h0, byte_of(packet_a, 2)}, {168'h0, 8'h13});
        player_y = 8'd19;
        step("y19_nopulse");
        check("y19_byte", {168'h0, byte_of(packet_a, 2)}, {168'h0, 8'h13});
        player_y = 8'd127;
        step("y127");
        player_y = 8'd128;
        step("y128");

        // Mid-operation reset: no pulse on reset, pulse on reload.
        rst = 1'b1;
        step("midreset");
        check("midreset_const", packet_a, {8'hAA, 168'h0});
        rst = 1'b0;
        step("reload");
        check("reload_upd_const", {175'h0, update_a}, {175'h0, 1'b1});
        step("reload_hold");

        // Randomized traffic with holds and occasional resets.
        for (int i = 0; i < 300; i++) begin
            int pick;
            pick = $urandom_range(0, 99);
            rst = (pick < 4);
            if (pick >= 35) randomize_inputs();
            else if (pick >= 25) player_x = 8'($urandom_range(40, 127));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
